// File: rtl/float_pkg.sv
// Shared single-precision constants, FSM/class enums and field helpers
// for the sequential floating-point divider.
package float_pkg;

  localparam int unsigned EXP_BIAS  = 127;
  localparam int unsigned EXP_MAX   = 255;
  localparam int unsigned QUOT_BITS = 26;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    StIdle,
    StUnpack,
    StDiv,
    StRound
  } divState_e;

  // Operand class decided in UNPACK; steers packing in ROUND.
  typedef enum logic [1:0] {
    ClsNormal,
    ClsNan,
    ClsDivZero,
    ClsZero
  } opClass_e;

  function automatic logic fSign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] fExp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] fFrac(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/floating_divider_seq_if.sv
// Request/result bundle of the sequential divider; the master issues
// operands and start, the slave (the divider) returns the registered result.
interface floating_divider_seq_if;

  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        exception;

  modport master (
    output a, b, start,
    input  busy, done, result, overflow, exception
  );

  modport slave (
    input  a, b, start,
    output busy, done, result, overflow, exception
  );

endinterface

// File: rtl/mantissa_div_core.sv
// Restoring mantissa divider: one quotient bit per step, with the
// remainder, quotient shift register and iteration counter.
module mantissa_div_core
  import float_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [24:0]          dividend,
  input  logic [23:0]          divisor,
  output logic [QUOT_BITS-1:0] q,
  output logic                 sticky,
  output logic                 last
);

  logic [24:0]          remQ;
  logic [23:0]          divQ;
  logic [QUOT_BITS-1:0] quotQ;
  logic [4:0]           cntQ;

  logic        remGeq;
  logic [24:0] remSub;
  logic [24:0] remNext;

  // Remainder stays below 2*divisor, so 25 bits never overflow on the shift.
  always_comb begin
    remGeq  = remQ >= {1'b0, divQ};
    remSub  = remGeq ? (remQ - {1'b0, divQ}) : remQ;
    remNext = {remSub[23:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remQ  <= '0;
      divQ  <= '0;
      quotQ <= '0;
      cntQ  <= '0;
    end else if (load) begin
      remQ  <= dividend;
      divQ  <= divisor;
      quotQ <= '0;
      cntQ  <= 5'(QUOT_BITS - 1);
    end else if (step) begin
      remQ  <= remNext;
      quotQ <= {quotQ[QUOT_BITS-2:0], remGeq};
      if (cntQ != 5'd0) begin
        cntQ <= cntQ - 5'd1;
      end
    end
  end

  assign q      = quotQ;
  assign sticky = remQ != 25'd0;
  assign last   = cntQ == 5'd0;

endmodule

// File: rtl/floating_divider_seq.sv
// Iterative IEEE-754 single-precision divider with fixed 29-cycle latency:
// FSM, unpack/classify, round-to-nearest-even and result packing.
module floating_divider_seq
  import float_pkg::*;
(
  input logic                   clk,
  input logic                   reset,
  floating_divider_seq_if.slave bus
);

  divState_e stateQ, stateD;

  logic [31:0]       aQ, bQ;
  logic              signQ;
  logic signed [9:0] expQ;
  opClass_e          clsQ;
  logic              busyQ, doneQ, ovfQ, excQ;
  logic [31:0]       resultQ;

  logic accept, load, step, finish;
  logic coreLast, coreSticky;
  logic [QUOT_BITS-1:0] coreQ;

  // Unpack / classify
  logic [23:0]       ma, mb;
  logic              aZero, bZero, aInfNan, bInfNan, maLess, signD;
  logic signed [9:0] expRaw, expNorm;
  logic [24:0]       remInit;
  opClass_e          clsD;

  always_comb begin
    ma      = {1'b1, fFrac(aQ)};
    mb      = {1'b1, fFrac(bQ)};
    aZero   = fExp(aQ) == 8'd0;
    bZero   = fExp(bQ) == 8'd0;
    aInfNan = fExp(aQ) == 8'(EXP_MAX);
    bInfNan = fExp(bQ) == 8'(EXP_MAX);
    signD   = fSign(aQ) ^ fSign(bQ);
    expRaw  = 10'({2'b00, fExp(aQ)}) - 10'({2'b00, fExp(bQ)}) + 10'(EXP_BIAS);
    maLess  = ma < mb;
    // Pre-normalise so the first quotient bit is always the integer 1.
    remInit = maLess ? {ma, 1'b0} : {1'b0, ma};
    expNorm = maLess ? (expRaw - 10'sd1) : expRaw;
    if (aInfNan || bInfNan || (aZero && bZero)) begin
      clsD = ClsNan;
    end else if (bZero) begin
      clsD = ClsDivZero;
    end else if (aZero) begin
      clsD = ClsZero;
    end else begin
      clsD = ClsNormal;
    end
  end

  mantissa_div_core u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .dividend (remInit),
    .divisor  (mb),
    .q        (coreQ),
    .sticky   (coreSticky),
    .last     (coreLast)
  );

  // Round and pack
  logic              guardBit, roundBit, lsbBit, roundInc, mantCarry, unusedHidden;
  logic [23:0]       mantSum;
  logic [22:0]       fracD;
  logic signed [9:0] expFinal;
  logic [31:0]       resultD;
  logic              ovfD, excD;

  always_comb begin
    guardBit     = coreQ[1];
    roundBit     = coreQ[0];
    lsbBit       = coreQ[2];
    roundInc     = guardBit & (roundBit | coreSticky | lsbBit);
    {mantCarry, mantSum} = {1'b0, coreQ[25:2]} + {24'd0, roundInc};
    unusedHidden = mantSum[23];
    fracD        = mantCarry ? 23'd0 : mantSum[22:0];
    expFinal     = mantCarry ? (expQ + 10'sd1) : expQ;

    resultD = '0;
    ovfD    = 1'b0;
    excD    = 1'b0;
    unique case (clsQ)
      ClsNan: begin
        resultD = QNAN;
        excD    = 1'b1;
      end
      ClsDivZero: begin
        resultD = {signQ, 8'hFF, 23'd0};
        excD    = 1'b1;
      end
      ClsZero: begin
        resultD = {signQ, 31'd0};
      end
      default: begin
        if (expFinal >= 10'sd255) begin
          resultD = {signQ, 8'hFF, 23'd0};
          ovfD    = 1'b1;
        end else if (expFinal <= 10'sd0) begin
          resultD = {signQ, 31'd0};
        end else begin
          resultD = {signQ, expFinal[7:0], fracD};
        end
      end
    endcase
  end

  // FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    accept = 1'b0;
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (bus.start) begin
          accept = 1'b1;
          stateD = StUnpack;
        end
      end
      StUnpack: begin
        load   = 1'b1;
        stateD = StDiv;
      end
      StDiv: begin
        step = 1'b1;
        if (coreLast) begin
          stateD = StRound;
        end
      end
      StRound: begin
        finish = 1'b1;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aQ      <= '0;
      bQ      <= '0;
      signQ   <= 1'b0;
      expQ    <= '0;
      clsQ    <= ClsNormal;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      resultQ <= '0;
      ovfQ    <= 1'b0;
      excQ    <= 1'b0;
    end else begin
      doneQ <= finish;
      if (accept) begin
        aQ    <= bus.a;
        bQ    <= bus.b;
        busyQ <= 1'b1;
      end
      if (load) begin
        signQ <= signD;
        expQ  <= expNorm;
        clsQ  <= clsD;
      end
      if (finish) begin
        busyQ   <= 1'b0;
        resultQ <= resultD;
        ovfQ    <= ovfD;
        excQ    <= excD;
      end
    end
  end

  assign bus.busy      = busyQ;
  assign bus.done      = doneQ;
  assign bus.result    = resultQ;
  assign bus.overflow  = ovfQ;
  assign bus.exception = excQ;

endmodule

// File: tb/tb_floating_divider_seq.sv
// Directed self-checking bench for floating_divider_seq.
module tb_floating_divider_seq;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   assertCount = 0;
  int   failCount   = 0;

  floating_divider_seq_if bus();

  floating_divider_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Called at a negedge; start is seen by the next rising edge (T0).
  task automatic issue(input logic [31:0] av, input logic [31:0] bv);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at the negedge of cycle 1; returns the cycle number of done.
  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, output logic [31:0] res,
                       output logic ovf, output logic exc, output int lat);
    @(negedge clk);
    issue(av, bv);
    wait_done(lat);
    res = bus.result;
    ovf = bus.overflow;
    exc = bus.exception;
  endtask

  task automatic test_reset();
    bus.a = '0; bus.b = '0; bus.start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    assertCount++;
    if ({bus.busy, bus.done, bus.overflow, bus.exception} !== 4'b0000) begin
      failCount++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.busy, bus.done, bus.overflow, bus.exception});
    end
    assertCount++;
    if (bus.result !== 32'h0) begin
      failCount++;
      $display("FAIL reset_result: got %h expected 00000000", bus.result);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] res; logic ovf, exc; int lat;
    do_op(32'h40C0_0000, 32'h4000_0000, res, ovf, exc, lat);
    assertCount++;
    if (res !== 32'h4040_0000) begin
      failCount++; $display("FAIL six_by_two: got %h expected 40400000", res);
    end
    assertCount++;
    if ({ovf, exc} !== 2'b00) begin
      failCount++; $display("FAIL six_by_two_flags: got %b expected 00", {ovf, exc});
    end
    assertCount++;
    if (lat !== 29) begin
      failCount++; $display("FAIL latency: got %0d expected 29", lat);
    end
    assertCount++;
    if (bus.busy !== 1'b0) begin
      failCount++; $display("FAIL busy_at_done: got %b expected 0", bus.busy);
    end
    @(negedge clk);
    assertCount++;
    if (bus.done !== 1'b0) begin
      failCount++; $display("FAIL done_single_pulse: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] res; logic ovf, exc; int lat;
    do_op(32'hC219_C000, 32'h40A4_0000, res, ovf, exc, lat);
    assertCount++;
    if (res !== 32'hC0F0_0000 || {ovf, exc} !== 2'b00) begin
      failCount++; $display("FAIL neg_div: got %h/%b expected c0f00000/00", res, {ovf, exc});
    end
    do_op(32'h3F80_0000, 32'h4040_0000, res, ovf, exc, lat);
    assertCount++;
    if (res !== 32'h3EAA_AAAB || {ovf, exc} !== 2'b00) begin
      failCount++; $display("FAIL one_third: got %h/%b expected 3eaaaaab/00", res, {ovf, exc});
    end
  endtask

  task automatic test_range();
    logic [31:0] res; logic ovf, exc; int lat;
    do_op(32'h7F00_0000, 32'h3E80_0000, res, ovf, exc, lat);
    assertCount++;
    if (res !== 32'h7F80_0000 || {ovf, exc} !== 2'b10) begin
      failCount++; $display("FAIL overflow: got %h/%b expected 7f800000/10", res, {ovf, exc});
    end
    do_op(32'h0080_0000, 32'h4B00_0000, res, ovf, exc, lat);
    assertCount++;
    if (res !== 32'h0000_0000 || {ovf, exc} !== 2'b00) begin
      failCount++; $display("FAIL underflow: got %h/%b expected 00000000/00", res, {ovf, exc});
    end
  endtask

  task automatic test_special();
    logic [31:0] res; logic ovf, exc; int lat;
    do_op(32'h3F80_0000, 32'h0000_0000, res, ovf, exc, lat);
    assertCount++;
    if (res !== 32'h7F80_0000 || {ovf, exc} !== 2'b01) begin
      failCount++; $display("FAIL div_by_zero: got %h/%b expected 7f800000/01", res, {ovf, exc});
    end
    assertCount++;
    if (lat !== 29) begin
      failCount++; $display("FAIL special_latency: got %0d expected 29", lat);
    end
    do_op(32'h0000_0000, 32'h0000_0000, res, ovf, exc, lat);
    assertCount++;
    if (res !== 32'h7FC0_0000 || {ovf, exc} !== 2'b01) begin
      failCount++; $display("FAIL zero_by_zero: got %h/%b expected 7fc00000/01", res, {ovf, exc});
    end
    do_op(32'h0000_0000, 32'h4EA0_C8E4, res, ovf, exc, lat);
    assertCount++;
    if (res !== 32'h0000_0000 || {ovf, exc} !== 2'b00) begin
      failCount++; $display("FAIL zero_dividend: got %h/%b expected 00000000/00", res, {ovf, exc});
    end
  endtask

  task automatic test_busy_ignore();
    int doneCnt = 0;
    int firstLat = 0;
    logic [31:0] res = '0;
    @(negedge clk);
    issue(32'h40C0_0000, 32'h4000_0000);
    for (int c = 1; c <= 60; c++) begin
      if (c == 5) begin
        bus.a = 32'h3F80_0000; bus.b = 32'h4040_0000; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        doneCnt++;
        if (doneCnt == 1) begin
          firstLat = c;
          res = bus.result;
        end
      end
      @(negedge clk);
    end
    assertCount++;
    if (doneCnt !== 1) begin
      failCount++; $display("FAIL busy_ignore_count: got %0d expected 1", doneCnt);
    end
    assertCount++;
    if (res !== 32'h4040_0000 || firstLat !== 29) begin
      failCount++;
      $display("FAIL busy_ignore_result: got %h@%0d expected 40400000@29", res, firstLat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; logic ovf, exc; int lat;
    do_op(32'h3F80_0000, 32'h4040_0000, res, ovf, exc, lat);
    assertCount++;
    if (res !== 32'h3EAA_AAAB) begin
      failCount++; $display("FAIL b2b_first: got %h expected 3eaaaaab", res);
    end
    issue(32'h40C0_0000, 32'h4000_0000);
    assertCount++;
    if (bus.busy !== 1'b1) begin
      failCount++; $display("FAIL b2b_accept: got busy %b expected 1", bus.busy);
    end
    wait_done(lat);
    assertCount++;
    if (bus.result !== 32'h4040_0000 || lat !== 29) begin
      failCount++;
      $display("FAIL b2b_second: got %h@%0d expected 40400000@29", bus.result, lat);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] res; logic ovf, exc; int lat;
    int doneCnt = 0;
    @(negedge clk);
    issue(32'h3F80_0000, 32'h4040_0000);
    repeat (10) @(negedge clk);
    assertCount++;
    if (bus.busy !== 1'b1 || bus.result === 32'h0) begin
      failCount++;
      $display("FAIL pre_reset_state: got busy %b result %h expected busy 1, result nonzero",
               bus.busy, bus.result);
    end
    reset = 1'b0;
    #1;
    assertCount++;
    if ({bus.busy, bus.done, bus.overflow, bus.exception} !== 4'b0000 ||
        bus.result !== 32'h0) begin
      failCount++;
      $display("FAIL async_reset: got %b/%h expected 0000/00000000",
               {bus.busy, bus.done, bus.overflow, bus.exception}, bus.result);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.done === 1'b1) doneCnt++;
      @(negedge clk);
    end
    assertCount++;
    if (doneCnt !== 0) begin
      failCount++; $display("FAIL no_done_after_reset: got %0d expected 0", doneCnt);
    end
    do_op(32'h40C0_0000, 32'h4000_0000, res, ovf, exc, lat);
    assertCount++;
    if (res !== 32'h4040_0000 || lat !== 29) begin
      failCount++;
      $display("FAIL post_reset_op: got %h@%0d expected 40400000@29", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_range();
    test_special();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/floating_divider_seq.md
# floating_divider_seq

Iterative IEEE-754 single-precision divider: the inverse operation of the registered floating multiplier, built for the same datapath. It accepts `a / b` on a start pulse and produces a rounded quotient with the same overflow/exception flag convention. A restoring mantissa divider retires one quotient bit per cycle, giving fixed latency.

## Interface
- No parameters; the format is fixed at 32-bit IEEE-754 single precision.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `a`  in  32  dividend; sampled only on an accepted start.
- `b`  in  32  divisor; sampled only on an accepted start.
- `start`  in  1  request; accepted only when `busy`=0.
- `busy`  out  1  operation in flight; reset value 0.
- `done`  out  1  single-cycle pulse marking a valid result; reset value 0.
- `result`  out  32  quotient; held until the next `done`; reset value 0.
- `overflow`  out  1  exponent overflow; qualified by `done`, held with `result`; reset value 0.
- `exception`  out  1  divide-by-zero, or an input with exponent 255; held with `result`; reset value 0.

## Operation
- FSM states: IDLE → UNPACK → DIV → ROUND → IDLE.
- IDLE
  - `start`=1: capture `a` and `b`, go to UNPACK.
  - `start` while busy is ignored, not queued.
- UNPACK
  - Sign = sa ^ sb.
  - Mantissas: ma = {1, fa}, mb = {1, fb}, 24 bits each.
  - Exponent: e = ea − eb + 127, held as 10-bit signed.
  - If ma < mb: ma <<= 1 and e −= 1, so the remainder starts in [mb, 2·mb).
  - Classify special cases (see below). Load the iteration counter with 25.
- DIV
  - Runs 26 cycles of restoring division.
  - Each cycle: if r ≥ mb then q bit = 1 and r −= mb, else q bit = 0; then r <<= 1.
  - The 26 quotient bits are 1 integer bit, 23 fraction bits, guard G, round R.
  - Leave DIV when the counter reaches 0.
- ROUND
  - Sticky S = (r ≠ 0).
  - Round to nearest even: increment when G & (R | S | lsb).
  - A carry out of the mantissa forces mantissa = 0 and e += 1.
  - e ≥ 255: result = {sign, 0xFF, 0}, `overflow`=1.
  - e ≤ 0: result = {sign, 31'b0} (flush to zero, no flag).
- Special cases
  - These still traverse all states, so latency is unchanged.
  - Denormal inputs (exp = 0) are treated as zero.
  - Either exponent = 255, or 0/0: result 0x7FC00000, `exception`=1.
  - b zero, a nonzero finite: result {sign, 0xFF, 0}, `exception`=1, `overflow`=0.
  - a zero, b nonzero finite: result {sign, 31'b0}, both flags 0.
- Reset asserted at any time, including mid-DIV: state goes to IDLE and all outputs go to reset values. The in-flight operation is discarded, with no `done`.

## Timing
- Start is accepted at rising edge T0. `busy` is high in cycles 1–28 after T0.
- In cycle 29:
  - `done`=1 with `result`, `overflow` and `exception` valid.
  - `busy`=0.
- A new `start` in the `done` cycle is accepted, so back-to-back throughput is 1 result per 29 cycles.
- Latency is identical for every operand class.
- `done` is never high for two consecutive cycles.
- All outputs are registered; there is no combinational path from the inputs to any output.

## Structure
- Shared package `float_pkg` holds:
  - `EXP_BIAS` = 127, `EXP_MAX` = 255, `QNAN` = 32'h7FC00000, `QUOT_BITS` = 26.
  - The FSM state enum.
  - Field-slicing helpers for sign, exponent and fraction.
- Natural sub-module: `mantissa_div_core`. It holds the 24-bit restoring iteration, quotient shift register, remainder and counter. Its controls are load/step, and its outputs are q[25:0] and sticky.
- The top level keeps the FSM, unpack/classify, rounding and packing.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) → 0x40400000, flags 0, `done` exactly 29 cycles after start.
- 0xC219C000 / 0x40A40000 (−38.4375/5.125) → 0xC0F00000. Then 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB, which exercises rounding up.
- 0x7F000000 / 0x3E800000 → 0x7F800000, `overflow`=1. Then 0x00800000 / 0x4B000000 → 0x00000000, flags 0.
- 0x3F800000 / 0 → 0x7F800000 with `exception`=1. Then 0/0 → 0x7FC00000 with `exception`=1. Then 0 / 0x4EA0C8E4 → 0.
- Pulse `start` again during `busy` → ignored; the original result is unchanged and only one `done` occurs. A back-to-back start in the `done` cycle is accepted.
- Drop `reset` low at DIV cycle 10 → `busy`, `done`, `result` and flags go to 0 immediately, and no `done` follows. After release, a fresh 6/2 division gives 0x40400000.
